// File: rtl/mem_io_pkg.sv
// Shared state encoding and parameter defaults for the
// memory / I/O controller.
package mem_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 20;
    localparam int N_HEX_DEF  = 4;
    localparam int WAIT_DEF   = 2;
    localparam int CNT_W      = 4;

    localparam logic [31:0] IO_ADDR_DEF = 32'hFFFF;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU, board and SRAM bus bundle of the memory / I/O controller.
// master = CPU/board/SRAM side, slave = controller side.
interface mem_io_ctrl_if #(
    parameter int DATA_W = mem_io_pkg::DATA_W_DEF,
    parameter int ADDR_W = mem_io_pkg::ADDR_W_DEF,
    parameter int N_HEX  = mem_io_pkg::N_HEX_DEF
) ();

    logic                Req;
    logic                WrEn;
    logic [ADDR_W-1:0]   Addr;
    logic [DATA_W-1:0]   Data_from_CPU;
    logic [DATA_W-1:0]   Data_to_CPU;
    logic                Ready;
    logic                Busy;

    logic [DATA_W-1:0]   Switches;
    logic [4*N_HEX-1:0]  Hex_out;

    logic                Mem_CE;
    logic                Mem_UB;
    logic                Mem_LB;
    logic                Mem_OE;
    logic                Mem_WE;
    logic [ADDR_W-1:0]   Mem_ADDR;
    logic [DATA_W-1:0]   Data_to_SRAM;
    logic [DATA_W-1:0]   Data_from_SRAM;
    logic                Mem_Drive;

    modport master (
        output Req,
        output WrEn,
        output Addr,
        output Data_from_CPU,
        output Switches,
        output Data_from_SRAM,
        input  Data_to_CPU,
        input  Ready,
        input  Busy,
        input  Hex_out,
        input  Mem_CE,
        input  Mem_UB,
        input  Mem_LB,
        input  Mem_OE,
        input  Mem_WE,
        input  Mem_ADDR,
        input  Data_to_SRAM,
        input  Mem_Drive
    );

    modport slave (
        input  Req,
        input  WrEn,
        input  Addr,
        input  Data_from_CPU,
        input  Switches,
        input  Data_from_SRAM,
        output Data_to_CPU,
        output Ready,
        output Busy,
        output Hex_out,
        output Mem_CE,
        output Mem_UB,
        output Mem_LB,
        output Mem_OE,
        output Mem_WE,
        output Mem_ADDR,
        output Data_to_SRAM,
        output Mem_Drive
    );

endinterface

// File: rtl/mem_io_regs.sv
// Hex display register and the read-data register fed from
// either the board switches or the SRAM data bus.
module mem_io_regs
    import mem_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_HEX  = N_HEX_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               io_rd_i,
    input  logic               sram_rd_i,
    input  logic               hex_wr_i,
    input  logic [DATA_W-1:0]  cpu_wdata_i,
    input  logic [DATA_W-1:0]  switches_i,
    input  logic [DATA_W-1:0]  sram_rdata_i,
    output logic [DATA_W-1:0]  rdata_o,
    output logic [4*N_HEX-1:0] hex_o
);

    localparam int HEX_W = 4 * N_HEX;

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [HEX_W-1:0]  hex_q, hex_d;

    // The cast truncates or zero-extends to the display width.
    always_comb begin
        hex_d = hex_q;
        if (hex_wr_i) begin
            hex_d = HEX_W'(cpu_wdata_i);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        unique case (1'b1)
            io_rd_i:   rdata_d = switches_i;
            sram_rd_i: rdata_d = sram_rdata_i;
            default:   ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rdata_q <= '0;
            hex_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
        end
    end

    assign rdata_o = rdata_q;
    assign hex_o   = hex_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory / I/O controller: CPU request FSM in front of an async
// SRAM, with one I/O-mapped address for switches and hex display.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int          DATA_W      = DATA_W_DEF,
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter int          WAIT_STATES = WAIT_DEF,
    parameter int          N_HEX       = N_HEX_DEF,
    parameter logic [31:0] IO_ADDR     = IO_ADDR_DEF
) (
    input logic          Clk,
    input logic          Reset,
    mem_io_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] IoAddr   = ADDR_W'(IO_ADDR);
    localparam logic [CNT_W-1:0]  CntLoad  = CNT_W'(WAIT_STATES);
    localparam bit                WeOneCyc = (WAIT_STATES == 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic is_io;
    logic accept;
    logic in_setup;
    logic in_access;
    logic last_access;
    logic sram_phase;
    logic io_rd;
    logic hex_wr;
    logic sram_rd;
    logic we_active;

    assign is_io       = (bus.Addr == IoAddr);
    assign accept      = (state_q == IDLE) && bus.Req;
    assign in_setup    = (state_q == SETUP);
    assign in_access   = (state_q == ACCESS);
    assign last_access = in_access && (cnt_q == '0);
    assign sram_phase  = in_setup || in_access;

    assign io_rd   = accept && is_io && !bus.WrEn;
    assign hex_wr  = accept && is_io && bus.WrEn;
    assign sram_rd = last_access && !wr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = bus.WrEn;
                    addr_d  = bus.Addr;
                    wdata_d = bus.Data_from_CPU;
                    state_d = is_io ? DONE : SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CntLoad;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The final ACCESS cycle holds data with WE released, unless
    // there is only one ACCESS cycle to strobe in.
    assign we_active = in_access && wr_q
                     && ((cnt_q != '0) || WeOneCyc);

    assign bus.Busy         = (state_q != IDLE);
    assign bus.Ready        = (state_q == DONE);
    assign bus.Mem_CE       = !sram_phase;
    assign bus.Mem_UB       = !sram_phase;
    assign bus.Mem_LB       = !sram_phase;
    assign bus.Mem_OE       = !(in_access && !wr_q);
    assign bus.Mem_WE       = !we_active;
    assign bus.Mem_Drive    = sram_phase && wr_q;
    assign bus.Mem_ADDR     = addr_q;
    assign bus.Data_to_SRAM = wdata_q;

    mem_io_regs #(
        .DATA_W (DATA_W),
        .N_HEX  (N_HEX)
    ) u_regs (
        .Clk          (Clk),
        .Reset        (Reset),
        .io_rd_i      (io_rd),
        .sram_rd_i    (sram_rd),
        .hex_wr_i     (hex_wr),
        .cpu_wdata_i  (bus.Data_from_CPU),
        .switches_i   (bus.Switches),
        .sram_rdata_i (bus.Data_from_SRAM),
        .rdata_o      (bus.Data_to_CPU),
        .hex_o        (bus.Hex_out)
    );

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: instances with 2 and 0 wait states,
// checked every cycle against a transaction-schedule model.
module tb_mem_io_ctrl;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int NH = 4;
    localparam int HW = 4 * NH;
    localparam logic [AW-1:0] IO_A = 20'h0FFFF;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    mem_io_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .N_HEX(NH)) ia ();
    mem_io_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .N_HEX(NH)) ib ();

    mem_io_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(2),
        .N_HEX(NH), .IO_ADDR(32'hFFFF)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(ia.slave)
    );

    mem_io_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(0),
        .N_HEX(NH), .IO_ADDR(32'hFFFF)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(ib.slave)
    );

    int errors = 0;
    int checks = 0;
    int n      = 0;

    // Model: per instance, the cycle a request was accepted and
    // its total latency; every output follows from the offset.
    bit            m_act [2];
    bit            m_io  [2];
    bit            m_wr  [2];
    int            c0    [2];
    int            lt    [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wdat[2];
    logic [DW-1:0] m_rdat[2];
    logic [HW-1:0] m_hex [2];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, got, exp, $time);
        end
    endtask

    task automatic mreset(input int k);
        m_act[k]  = 1'b0;
        m_io[k]   = 1'b0;
        m_wr[k]   = 1'b0;
        c0[k]     = 0;
        lt[k]     = 0;
        m_addr[k] = '0;
        m_wdat[k] = '0;
        m_rdat[k] = '0;
        m_hex[k]  = '0;
    endtask

    task automatic mstep(input int k, input int ws,
                         input logic req, input logic wr,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         input logic [DW-1:0] sw,
                         input logic [DW-1:0] sr);
        int r;
        bit idle;
        r = n - c0[k];
        if (m_act[k] && !m_io[k] && !m_wr[k] && r == ws + 2)
            m_rdat[k] = sr;
        idle = !m_act[k] || (r > lt[k]);
        if (idle && req) begin
            m_act[k]  = 1'b1;
            c0[k]     = n;
            m_io[k]   = (a == IO_A);
            m_wr[k]   = wr;
            m_addr[k] = a;
            m_wdat[k] = d;
            lt[k]     = m_io[k] ? 1 : ws + 3;
            if (m_io[k] && wr)  m_hex[k]  = d;
            if (m_io[k] && !wr) m_rdat[k] = sw;
        end
    endtask

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, 2, ia.Req, ia.WrEn, ia.Addr, ia.Data_from_CPU,
                  ia.Switches, ia.Data_from_SRAM);
            mstep(1, 0, ib.Req, ib.WrEn, ib.Addr, ib.Data_from_CPU,
                  ib.Switches, ib.Data_from_SRAM);
            n++;
        end
    end

    task automatic cmp(input string nm, input int k, input int ws,
                       input logic bsy, input logic rdy,
                       input logic ce, input logic ub, input logic lb,
                       input logic oe, input logic we, input logic drv,
                       input logic [AW-1:0] ma,
                       input logic [DW-1:0] ds,
                       input logic [DW-1:0] dc,
                       input logic [HW-1:0] hx);
        int r;
        bit b;
        bit sr;
        bit we_l;
        r    = n - c0[k];
        b    = m_act[k] && r >= 1 && r <= lt[k];
        sr   = b && !m_io[k] && r <= ws + 2;
        we_l = sr && m_wr[k] && r >= 2 && (r <= ws + 1 || ws == 0);
        chk({nm, " Busy"},  bsy, b);
        chk({nm, " Ready"}, rdy, b && r == lt[k]);
        chk({nm, " CE"},    ce, !sr);
        chk({nm, " UB"},    ub, !sr);
        chk({nm, " LB"},    lb, !sr);
        chk({nm, " OE"},    oe, !(sr && !m_wr[k] && r >= 2));
        chk({nm, " WE"},    we, !we_l);
        chk({nm, " Drive"}, drv, sr && m_wr[k]);
        chk({nm, " ADDR"},  ma, m_addr[k]);
        chk({nm, " DtoS"},  ds, m_wdat[k]);
        chk({nm, " DtoC"},  dc, m_rdat[k]);
        chk({nm, " Hex"},   hx, m_hex[k]);
    endtask

    always @(negedge Clk) begin
        cmp("A", 0, 2, ia.Busy, ia.Ready, ia.Mem_CE, ia.Mem_UB,
            ia.Mem_LB, ia.Mem_OE, ia.Mem_WE, ia.Mem_Drive,
            ia.Mem_ADDR, ia.Data_to_SRAM, ia.Data_to_CPU, ia.Hex_out);
        cmp("B", 1, 0, ib.Busy, ib.Ready, ib.Mem_CE, ib.Mem_UB,
            ib.Mem_LB, ib.Mem_OE, ib.Mem_WE, ib.Mem_Drive,
            ib.Mem_ADDR, ib.Data_to_SRAM, ib.Data_to_CPU, ib.Hex_out);
    end

    // Issues one request on instance A from the current negedge
    // and counts strobe cycles until Ready (bounded).
    task automatic run_a(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat,
                         output int ce_n, output int oe_n,
                         output int we_n, output int drv_n);
        lat = -1; ce_n = 0; oe_n = 0; we_n = 0; drv_n = 0;
        ia.Req = 1'b1;
        ia.WrEn = wr;
        ia.Addr = a;
        ia.Data_from_CPU = d;
        @(posedge Clk);
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            @(negedge Clk);
            if (i == 1) begin
                ia.Req = 1'b0;
                ia.WrEn = ~wr;
                ia.Addr = AW'($urandom);
                ia.Data_from_CPU = DW'($urandom);
            end
            if (!ia.Mem_CE)   ce_n++;
            if (!ia.Mem_OE)   oe_n++;
            if (!ia.Mem_WE)   we_n++;
            if (ia.Mem_Drive) drv_n++;
            if (ia.Ready)     lat = i;
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return IO_A;
            1:       return 20'hFFFFF;
            default: return AW'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, ce_n, oe_n, we_n, drv_n, rdy_n, first, second;
        ia.Req = 0; ia.WrEn = 0; ia.Addr = '0;
        ia.Data_from_CPU = '0; ia.Switches = '0;
        ia.Data_from_SRAM = '0;
        ib.Req = 0; ib.WrEn = 0; ib.Addr = '0;
        ib.Data_from_CPU = '0; ib.Switches = '0;
        ib.Data_from_SRAM = '0;

        repeat (2) @(negedge Clk);
        chk("rst Busy",  ia.Busy, 0);
        chk("rst Ready", ia.Ready, 0);
        chk("rst CE",    ia.Mem_CE, 1);
        chk("rst WE",    ia.Mem_WE, 1);
        chk("rst Drive", ia.Mem_Drive, 0);
        chk("rst DtoC",  ia.Data_to_CPU, 0);
        chk("rst Hex",   ia.Hex_out, 0);

        // Req already high when reset releases: first edge accepts.
        Reset = 1'b1;
        ia.Data_from_SRAM = 16'hBEEF;
        run_a(1'b0, 20'h00010, 16'h0, lat, ce_n, oe_n, we_n, drv_n);
        chk("rd latency", lat, 5);
        chk("rd OE cycles", oe_n, 3);
        chk("rd CE cycles", ce_n, 4);
        chk("rd WE cycles", we_n, 0);
        chk("rd data", ia.Data_to_CPU, 16'hBEEF);

        @(negedge Clk);
        run_a(1'b1, 20'h00020, 16'h1234, lat, ce_n, oe_n, we_n, drv_n);
        chk("wr latency", lat, 5);
        chk("wr Drive cycles", drv_n, 4);
        chk("wr WE cycles", we_n, 2);
        chk("wr OE cycles", oe_n, 0);

        @(negedge Clk);
        run_a(1'b1, 20'h0FFFF, 16'hA5C3, lat, ce_n, oe_n, we_n, drv_n);
        chk("io wr latency", lat, 1);
        chk("io wr Hex", ia.Hex_out, 16'hA5C3);
        chk("io wr strobes", ce_n + oe_n + we_n + drv_n, 0);

        @(negedge Clk);
        ia.Switches = 16'h0F0F;
        run_a(1'b0, 20'h0FFFF, 16'h0, lat, ce_n, oe_n, we_n, drv_n);
        chk("io rd latency", lat, 1);
        chk("io rd data", ia.Data_to_CPU, 16'h0F0F);
        chk("io rd strobes", ce_n + oe_n + we_n + drv_n, 0);

        // Reset pulse in the first ACCESS cycle of an SRAM write.
        @(negedge Clk);
        ia.Req = 1'b1; ia.WrEn = 1'b1;
        ia.Addr = 20'h00040; ia.Data_from_CPU = 16'h5555;
        @(posedge Clk);
        @(negedge Clk);
        ia.Req = 1'b0;
        @(negedge Clk);
        chk("pre-rst WE", ia.Mem_WE, 0);
        #2 Reset = 1'b0;
        #1;
        chk("async rst CE", ia.Mem_CE, 1);
        chk("async rst WE", ia.Mem_WE, 1);
        chk("async rst Drive", ia.Mem_Drive, 0);
        chk("async rst Busy", ia.Busy, 0);
        chk("async rst Hex", ia.Hex_out, 0);
        @(negedge Clk);
        Reset = 1'b1;
        rdy_n = 0;
        repeat (8) begin
            @(negedge Clk);
            if (ia.Ready) rdy_n++;
        end
        chk("rst no Ready", rdy_n, 0);

        // Zero wait states, Req held high across two reads.
        ib.Req = 1'b1; ib.WrEn = 1'b0; ib.Addr = 20'h00100;
        first = -1; second = -1; rdy_n = 0;
        @(posedge Clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (ib.Ready) begin
                rdy_n++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (i == 7) ib.Req = 1'b0;
        end
        chk("b2b first Ready", first, 3);
        chk("b2b second Ready", second, 7);
        chk("b2b Ready count", rdy_n, 2);

        for (int i = 0; i < 1500; i++) begin
            @(negedge Clk);
            ia.Req = ($urandom_range(0, 3) != 0);
            ia.WrEn = 1'($urandom_range(0, 1));
            ia.Addr = pick_addr();
            ia.Data_from_CPU = DW'($urandom);
            ia.Switches = DW'($urandom);
            ia.Data_from_SRAM = DW'($urandom);
            ib.Req = ($urandom_range(0, 3) != 0);
            ib.WrEn = 1'($urandom_range(0, 1));
            ib.Addr = pick_addr();
            ib.Data_from_CPU = DW'($urandom);
            ib.Switches = DW'($urandom);
            ib.Data_from_SRAM = DW'($urandom);
            if (i == 700) begin
                #3 Reset = 1'b0;
                #1 Reset = 1'b1;
            end
        end

        @(negedge Clk);
        ia.Req = 1'b0;
        ib.Req = 1'b0;
        repeat (10) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the CPU/SRAM data width.
REQ-002 The block SHALL have parameter ADDR_W, default 20, giving the SRAM address width.
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, legal range 0..15, giving extra SRAM access cycles.
REQ-004 The block SHALL have parameter N_HEX, default 4, giving the number of 4-bit hex display nibbles.
REQ-005 The block SHALL have parameter IO_ADDR, default 'hFFFF, giving the I/O-mapped address, zero-extended to ADDR_W.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset; the ports are named Clk and Reset.
REQ-007 Clk  in  1  system clock; all state changes on the rising edge.
REQ-008 Reset  in  1  asynchronous active-low reset.
REQ-009 Req  in  1  CPU access request, sampled only in IDLE.
REQ-010 WrEn  in  1  1 = write, 0 = read; latched with Req.
REQ-011 Addr  in  ADDR_W  access address; latched with Req.
REQ-012 Data_from_CPU  in  DATA_W  write data; latched with Req.
REQ-013 Data_to_CPU  out  DATA_W  last read data; held until the next read completes.
REQ-014 Ready  out  1  one-cycle completion pulse.
REQ-015 Busy  out  1  high in every state except IDLE.
REQ-016 Switches  in  DATA_W  board switches, read at IO_ADDR.
REQ-017 Hex_out  out  4*N_HEX  hex display register; nibble i drives digit i.
REQ-018 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.
REQ-019 Mem_ADDR  out  ADDR_W  SRAM address, driven from the latched address.
REQ-020 Data_to_SRAM  out  DATA_W  write data; Mem_Drive  out  1  tristate output enable, high = drive.
REQ-021 Data_from_SRAM  in  DATA_W  SRAM read data.

Function
REQ-022 The FSM SHALL have four states: IDLE, SETUP, ACCESS and DONE.
REQ-023 In IDLE with Req=1, the FSM SHALL latch WrEn, Addr and Data_from_CPU, then go to DONE if the latched address equals IO_ADDR, else to SETUP.
REQ-024 SETUP SHALL last 1 cycle and then go to ACCESS; ACCESS SHALL last exactly WAIT_STATES+1 cycles, counted by a down-counter, and then go to DONE.
REQ-025 DONE SHALL last 1 cycle with Ready=1 and then go to IDLE unconditionally, so back-to-back requests are spaced at least one IDLE cycle apart.
REQ-026 Latency: for Req accepted in cycle c, SRAM access SHALL give Ready in cycle c+WAIT_STATES+3, and I/O access SHALL give Ready in cycle c+1.
REQ-027 Mem_CE, Mem_UB and Mem_LB SHALL be low in SETUP and ACCESS, and high otherwise.
REQ-028 For reads, Mem_OE SHALL be low in ACCESS; Data_from_SRAM SHALL be captured into Data_to_CPU on the last ACCESS cycle.
REQ-029 For writes, Mem_Drive SHALL be high in SETUP and ACCESS; Mem_WE SHALL be low in ACCESS except its final cycle, which is the data-hold cycle; when WAIT_STATES=0, Mem_WE SHALL be low for that single ACCESS cycle.
REQ-030 An I/O read SHALL load Switches into Data_to_CPU at the IDLE-to-DONE edge.
REQ-031 An I/O write SHALL load Data_from_CPU[4*N_HEX-1:0] into the hex register; if 4*N_HEX > DATA_W, the result SHALL be zero-extended.
REQ-032 An I/O access SHALL not assert any SRAM strobe.
REQ-033 Req SHALL be ignored while Busy=1; changes to Addr/WrEn/Data_from_CPU during Busy SHALL have no effect.
REQ-034 Mem_ADDR and Data_to_SRAM SHALL be stable from SETUP through the end of ACCESS.

Reset
REQ-035 While Reset=0, the block SHALL be in IDLE, with Busy=0, Ready=0, all Mem_* strobes=1, Mem_Drive=0, Data_to_CPU=0, Hex_out=0, latched address/data=0 and the counter=0.
REQ-036 Reset asserted mid-access SHALL immediately deassert all strobes and Mem_Drive, with no Ready pulse and no hex register update.
REQ-037 After reset is released, the first Req SHALL be accepted on the first rising edge.

Structure
REQ-038 Package mem_io_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, DONE) and the default IO_ADDR constant.
REQ-039 One sub-module, mem_io_regs, SHALL hold the hex register and the switch/SRAM read-data mux; the FSM and counter SHALL live in mem_io_ctrl.

Verification
REQ-040 The bench SHALL cover: WAIT_STATES=2, read Addr=0x00010 with SRAM returning 0xBEEF -> Mem_OE low 3 cycles, Ready in cycle c+5, Data_to_CPU=0xBEEF.
REQ-041 The bench SHALL cover: WAIT_STATES=2, write 0x1234 to 0x00020 -> Mem_Drive high 4 cycles, Mem_WE low 2 cycles, Ready in cycle c+5.
REQ-042 The bench SHALL cover: write 0xA5C3 to 0xFFFF -> Ready in cycle c+1, Hex_out=0xA5C3, no SRAM strobe asserted.
REQ-043 The bench SHALL cover: Switches=0x0F0F, read 0xFFFF -> Ready in cycle c+1, Data_to_CPU=0x0F0F.
REQ-044 The bench SHALL cover: Reset pulsed low during ACCESS of a write -> strobes high asynchronously, no Ready pulse, state IDLE, Hex_out=0.
REQ-045 The bench SHALL cover: WAIT_STATES=0, two back-to-back reads with Req held high -> Ready in cycles c+3 and c+7, and Req ignored while Busy=1.
